// File: rtl/conv_pkg.sv
// Purpose : shared types and constants for the convolution tile engine.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: FSM state enum, default word/fraction/accumulator widths,
//           saturation limits for the default word width, index-width helper.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } conv_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;
  localparam int DEF_ACC_WIDTH  = 40;

  // Saturation limits of a DEF_DATA_WIDTH signed word.
  localparam logic signed [DEF_DATA_WIDTH-1:0] SAT_HI = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_DATA_WIDTH-1:0] SAT_LO = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

  // Width of an index counting 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_tile_engine_if.sv
// Purpose : pixel-in / tile-out handshake bundle of the convolution tile engine.
// Latency : n/a (wiring only).
// Backpr. : pix_valid/pix_ready on input beats, out_valid/out_ready on result tiles.
// Modports: master = beat source and tile sink (testbench / upstream),
//           slave  = the engine itself.
interface conv_tile_engine_if #(
  parameter int ARRAY_SIZE   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int TAPS         = 9,
  parameter int NUM_FEATURES = 4
);
  import conv_pkg::*;

  localparam int TAP_W  = idx_w(TAPS);
  localparam int FEAT_W = idx_w(NUM_FEATURES);

  logic                           pix_valid;
  logic                           pix_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] pix_bus;
  logic [DATA_WIDTH-1:0]          weight;
  logic [TAP_W-1:0]               tap_idx;
  logic [FEAT_W-1:0]              feature_idx;
  logic                           out_valid;
  logic                           out_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_bus;
  logic                           out_last;

  modport master (
    output pix_valid, pix_bus, weight, out_ready,
    input  pix_ready, tap_idx, feature_idx, out_valid, out_bus, out_last
  );

  modport slave (
    input  pix_valid, pix_bus, weight, out_ready,
    output pix_ready, tap_idx, feature_idx, out_valid, out_bus, out_last
  );

endinterface

// File: rtl/conv_mac_lane.sv
// Purpose : one output lane: signed MAC over a tile, then shift, saturate, optional ReLU.
// Latency : result register loads on the last tap beat, visible the next cycle.
// Backpr. : none locally; the top only pulses acc_en_i on accepted beats.
// Ports   : clk, rst_n; acc_en_i (accepted beat), first_i (tap 0 restarts the sum),
//           last_i (final tap, latch result), pix_i/weight_i operands, res_o result word.
// Build   : define CONV_TILE_RELU_EN to clamp negative results to zero.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         acc_en_i,
  input  logic                         first_i,
  input  logic                         last_i,
  input  logic signed [DATA_WIDTH-1:0] pix_i,
  input  logic signed [DATA_WIDTH-1:0] weight_i,
  output logic signed [DATA_WIDTH-1:0] res_o
);

  localparam logic signed [ACC_WIDTH-1:0] LIM_HI =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] LIM_LO =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d, acc_base, shifted;
  logic signed [DATA_WIDTH-1:0]   res_q, res_d;

  assign prod = pix_i * weight_i;

  always_comb begin
    // Tap 0 starts a fresh sum, so an aborted tile never leaks into the next one.
    acc_base = first_i ? '0 : acc_q;
    acc_d    = acc_base + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    shifted  = acc_d >>> FRAC_BITS;
    if (shifted > LIM_HI) begin
      res_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < LIM_LO) begin
      res_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res_d = shifted[DATA_WIDTH-1:0];
    end
`ifdef CONV_TILE_RELU_EN
    if (res_d[DATA_WIDTH-1]) begin
      res_d = '0;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      res_q <= '0;
    end else if (acc_en_i) begin
      acc_q <= acc_d;
      if (last_i) begin
        res_q <= res_d;
      end
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/conv_tile_engine.sv
// Purpose : convolution tile engine: ARRAY_SIZE lanes accumulate TAPS beats into one tile per feature.
// Latency : out_valid rises the cycle after the last tap beat is accepted.
// Backpr. : tile held stable until out_ready; no input beats accepted while a tile is pending.
// Ports   : clk, rst_n (async active-low), enable (run permission),
//           bus (slave side of conv_tile_engine_if: pixel beats in, result tiles out).
// Build   : CONV_TILE_RELU_EN selects fused ReLU in the lanes; timing is identical either way.
module conv_tile_engine
  import conv_pkg::*;
#(
  parameter int ARRAY_SIZE   = 6,
  parameter int KERNEL_SIZE  = 3,
  parameter int NUM_CHANNELS = 1,
  parameter int NUM_FEATURES = 4,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FRAC_BITS    = DEF_FRAC_BITS,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  conv_tile_engine_if.slave bus
);

  localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE * NUM_CHANNELS;
  localparam int TAP_W  = idx_w(TAPS);
  localparam int FEAT_W = idx_w(NUM_FEATURES);
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS - 1);
  localparam logic [FEAT_W-1:0] FEAT_LAST = FEAT_W'(NUM_FEATURES - 1);

  conv_state_e       state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [FEAT_W-1:0] feat_q, feat_d;
  logic              beat, last_beat, first_tap;
  logic              pix_ready, out_valid;

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    feat_d    = feat_q;
    pix_ready = 1'b0;
    out_valid = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        pix_ready = 1'b1;
        // Losing enable abandons the partial tile; a beat offered in that
        // same cycle is dropped with it.
        if (!enable) begin
          state_d = ST_IDLE;
          tap_d   = '0;
        end else if (bus.pix_valid) begin
          beat = 1'b1;
          if (tap_q == TAP_LAST) begin
            last_beat = 1'b1;
            tap_d     = '0;
            state_d   = ST_OUTPUT;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      ST_OUTPUT: begin
        // enable is only consulted after the handshake, so the tile is never dropped.
        out_valid = 1'b1;
        if (bus.out_ready) begin
          feat_d  = (feat_q == FEAT_LAST) ? '0 : feat_q + 1'b1;
          state_d = enable ? ST_ACCUM : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      feat_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      feat_q  <= feat_d;
    end
  end

  assign first_tap       = (tap_q == '0);
  assign bus.pix_ready   = pix_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_last    = out_valid && (feat_q == FEAT_LAST);
  assign bus.tap_idx     = tap_q;
  assign bus.feature_idx = feat_q;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    // Lane 0 occupies the most significant word of both buses.
    conv_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .acc_en_i (beat),
      .first_i  (first_tap),
      .last_i   (last_beat),
      .pix_i    (bus.pix_bus[(ARRAY_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH]),
      .weight_i (bus.weight),
      .res_o    (bus.out_bus[(ARRAY_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_conv_tile_engine.sv
// Purpose : directed self-checking bench for conv_tile_engine with an expected-tile queue.
// Latency : checks out_valid exactly one cycle after the last beat.
// Backpr. : exercises out_ready held low, enable drop, abort and mid-tile reset.
module tb_conv_tile_engine;
  import conv_pkg::*;

  localparam int AS   = 6;
  localparam int DW   = 16;
  localparam int NF   = 4;
  localparam int TAPS = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  always #5 clk = ~clk;

  conv_tile_engine_if #(
    .ARRAY_SIZE(AS), .DATA_WIDTH(DW), .TAPS(TAPS), .NUM_FEATURES(NF)
  ) bus_if ();

  conv_tile_engine #(
    .ARRAY_SIZE(AS), .KERNEL_SIZE(3), .NUM_CHANNELS(1), .NUM_FEATURES(NF),
    .DATA_WIDTH(DW), .FRAC_BITS(8), .ACC_WIDTH(40)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus_if.slave)
  );

  typedef struct {
    logic [AS*DW-1:0] bus;
    logic [1:0]       feat;
    logic             last;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp    = 0;
  int     n_err    = 0;
  int     exp_feat = 0;
  longint macc[AS];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_lane(input longint acc);
    longint sh;
    logic [DW-1:0] r;
    sh = acc >>> 8;
    if (sh > 32767)       r = SAT_HI;
    else if (sh < -32768) r = SAT_LO;
    else                  r = sh[DW-1:0];
`ifdef CONV_TILE_RELU_EN
    if (r[DW-1]) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [DW-1:0] pix_of(input int mode, input int lane, input int beat,
                                           input logic [DW-1:0] c);
    int v;
    v = int'(c);
    if (mode == 1) v = v + lane * 37 - beat * 50;
    return v[DW-1:0];
  endfunction

  // Drives nbeats accepted beats; when push is set, queues the expected tile
  // (either the model result or a fixed constant).
  task automatic do_tile(input int nbeats, input int mode, input logic [DW-1:0] c,
                         input logic [DW-1:0] w, input bit push, input bit use_fix,
                         input logic [AS*DW-1:0] fix);
    logic [AS*DW-1:0] pb;
    logic [DW-1:0]    p, wt;
    exp_t             e;
    int               n;
    for (int b = 0; b < nbeats; b++) begin
      wt = (mode == 1) ? w + DW'(b * 3) : w;
      for (int l = 0; l < AS; l++) begin
        p = pix_of(mode, l, b, c);
        pb[(AS-l)*DW-1 -: DW] = p;
        if (b == 0) macc[l] = 0;
        macc[l] += longint'($signed(p)) * longint'($signed(wt));
      end
      chk("tap_idx", bus_if.tap_idx, b);
      bus_if.pix_valid = 1'b1;
      bus_if.pix_bus   = pb;
      bus_if.weight    = wt;
      n = 0;
      while (!bus_if.pix_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("pix_ready", bus_if.pix_ready, 1);
      @(posedge clk); #1;
    end
    bus_if.pix_valid = 1'b0;
    if (push) begin
      for (int l = 0; l < AS; l++) e.bus[(AS-l)*DW-1 -: DW] = model_lane(macc[l]);
      if (use_fix) e.bus = fix;
      e.feat = 2'(exp_feat);
      e.last = (exp_feat == NF - 1);
      sb.push_back(e);
    end
  endtask

  // Called right after the last beat: out_valid must already be high.
  task automatic collect(input int hold);
    exp_t e;
    int   n;
    chk("out_valid_latency", bus_if.out_valid, 1);
    n = 0;
    while (!bus_if.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: observed empty queue expected a pending tile");
      return;
    end
    e = sb.pop_front();
    bus_if.out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      chk("hold_out_bus", bus_if.out_bus, e.bus);
      chk("hold_out_valid", bus_if.out_valid, 1);
      chk("hold_pix_ready", bus_if.pix_ready, 0);
      chk("hold_tap_idx", bus_if.tap_idx, 0);
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    chk("out_bus", bus_if.out_bus, e.bus);
    chk("feature_idx", bus_if.feature_idx, e.feat);
    chk("out_last", bus_if.out_last, e.last);
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    chk("post_out_valid", bus_if.out_valid, 0);
    exp_feat = (exp_feat + 1) % NF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AS*DW-1:0] fix;
    rst_n            = 1'b0;
    enable           = 1'b0;
    bus_if.pix_valid = 1'b0;
    bus_if.pix_bus   = '0;
    bus_if.weight    = '0;
    bus_if.out_ready = 1'b0;
    #12;
    chk("rst_pix_ready", bus_if.pix_ready, 0);
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_out_last", bus_if.out_last, 0);
    chk("rst_tap_idx", bus_if.tap_idx, 0);
    chk("rst_feature_idx", bus_if.feature_idx, 0);
    chk("rst_out_bus", bus_if.out_bus, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_pix_ready", bus_if.pix_ready, 0);
    enable = 1'b1;
    @(posedge clk); #1;

    // Single tile: 1.0 * 0.5 over 9 taps = 4.5 on every lane.
    fix = {AS{16'h0480}};
    do_tile(9, 0, 16'h0100, 16'h0080, 1, 1, fix);
    collect(0);

    // Backpressure with enable dropped while the tile is pending.
    do_tile(9, 1, 16'h0040, 16'hFF80, 1, 0, '0);
    enable = 1'b0;
    collect(5);
    chk("after_drop_pix_ready", bus_if.pix_ready, 0);
    enable = 1'b1;
    @(posedge clk); #1;

    // Positive and negative saturation.
    fix = {AS{16'h7FFF}};
    do_tile(9, 0, 16'h7FFF, 16'h7FFF, 1, 1, fix);
    collect(0);
`ifdef CONV_TILE_RELU_EN
    fix = '0;
`else
    fix = {AS{16'h8000}};
`endif
    do_tile(9, 0, 16'h8001, 16'h7FFF, 1, 1, fix);
    collect(0);

    // Varied data; feature index wraps back to 0 here.
    do_tile(9, 1, 16'hFC00, 16'h0100, 1, 0, '0);
    collect(0);

    // Abort after 4 beats, then a clean tile on the same feature.
    do_tile(4, 1, 16'h0300, 16'h0200, 0, 0, '0);
    enable = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("abort_out_valid", bus_if.out_valid, 0);
      chk("abort_tap_idx", bus_if.tap_idx, 0);
      chk("abort_feature_idx", bus_if.feature_idx, exp_feat);
      @(posedge clk); #1;
    end
    enable = 1'b1;
    @(posedge clk); #1;
    fix = {AS{16'h1B00}};
    do_tile(9, 0, 16'h0200, 16'h0180, 1, 1, fix);
    collect(0);

    // Reset in the middle of a tile.
    do_tile(6, 1, 16'h0500, 16'h0300, 0, 0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_bus", bus_if.out_bus, 0);
    chk("midrst_tap_idx", bus_if.tap_idx, 0);
    chk("midrst_feature_idx", bus_if.feature_idx, 0);
    chk("midrst_pix_ready", bus_if.pix_ready, 0);
    chk("midrst_out_valid", bus_if.out_valid, 0);
    exp_feat = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("postrst_out_valid", bus_if.out_valid, 0);
    end
    do_tile(9, 1, 16'h0123, 16'h00F0, 1, 0, '0);
    collect(0);

    // Four more tiles: features 1,2,3 then wrap to 0; out_last only on feature 3.
    for (int k = 0; k < 4; k++) begin
      do_tile(9, 1, 16'(16'h0010 + k * 16'h0111), 16'(16'hFF00 + k * 16'h0070), 1, 0, '0);
      collect(k == 1 ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_tile_engine.md
CONV_TILE_ENGINE -- requirements
Module: conv_tile_engine

Interface
REQ-001 SHALL have parameters: ARRAY_SIZE 6 (parallel output lanes); KERNEL_SIZE 3 (kernel edge); NUM_CHANNELS 1 (input channels); NUM_FEATURES 4 (output feature maps); DATA_WIDTH 16 (signed fixed-point word); FRAC_BITS 8 (fraction bits); ACC_WIDTH 40 (accumulator width).
REQ-002 SHALL derive TAPS = KERNEL_SIZE*KERNEL_SIZE*NUM_CHANNELS.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run permission.
- pix_valid  in  1  input beat valid.
- pix_ready  out  1  input beat accepted when high with pix_valid.
- pix_bus  in  ARRAY_SIZE*DATA_WIDTH  one pixel per lane; lane 0 in MSBs.
- weight  in  DATA_WIDTH  weight for the current tap, qualified by pix_valid.
- tap_idx  out  clog2(TAPS)  index of the next tap expected.
- feature_idx  out  clog2(NUM_FEATURES)  feature map of the current tile.
- out_valid  out  1  result tile valid.
- out_ready  in  1  downstream accepts the tile.
- out_bus  out  ARRAY_SIZE*DATA_WIDTH  result tile; lane 0 in MSBs.
- out_last  out  1  tile belongs to feature NUM_FEATURES-1.

Function
REQ-004 SHALL implement FSM states IDLE, ACCUM, OUTPUT.
REQ-005 IDLE: pix_ready=0; go to ACCUM on enable=1.
REQ-006 ACCUM: pix_ready=1; on each accepted beat, every lane i SHALL compute acc[i] = (tap_idx==0 ? 0 : acc[i]) + pix[i]*weight, as a signed full product sign-extended to ACC_WIDTH.
REQ-007 tap_idx SHALL increment per accepted beat and wrap to 0 after TAPS-1; the beat with tap_idx==TAPS-1 SHALL move the FSM to OUTPUT.
REQ-008 out_valid SHALL assert in the cycle after the last beat is accepted (1-cycle latency), and out_bus SHALL hold stable until out_valid && out_ready.
REQ-009 out_bus lane SHALL be acc arithmetically right-shifted by FRAC_BITS, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-010 On the out_valid && out_ready handshake:
- feature_idx SHALL increment, wrapping NUM_FEATURES-1 to 0.
- The FSM SHALL go to ACCUM if enable=1, otherwise to IDLE.
REQ-011 In OUTPUT, pix_ready SHALL be 0; no new beat is accepted until the handshake completes (no overlap).
REQ-012 If enable falls during ACCUM, the partial tile SHALL be discarded: tap_idx cleared, FSM goes to IDLE, feature_idx unchanged.
REQ-013 enable falling during OUTPUT SHALL NOT drop the pending tile.
REQ-014 out_last SHALL equal out_valid && (feature_idx==NUM_FEATURES-1).

Reset
REQ-015 On rst_n=0, asynchronously:
- FSM in IDLE.
- pix_ready, out_valid, out_last, tap_idx, feature_idx all 0.
- out_bus and accumulators all 0.
REQ-016 Reset asserted mid-tile SHALL discard all partial results; no out_valid follows the release of reset.

Configuration
REQ-017 With CONV_TILE_RELU_EN defined, each saturated lane with a negative value SHALL output 0 (fused ReLU).
REQ-018 Without CONV_TILE_RELU_EN, signed values SHALL pass through unchanged; there SHALL be no timing or latency difference between the two builds.

Structure
REQ-019 Package conv_pkg SHALL hold:
- the FSM state enum.
- default DATA_WIDTH, FRAC_BITS, and ACC_WIDTH constants.
- the saturation limit constants.
REQ-020 SHALL instantiate sub-module conv_mac_lane ARRAY_SIZE times via generate. Each lane performs the multiply-accumulate, shift, saturation and optional ReLU.
REQ-021 The top level SHALL contain only the FSM, the counters and the handshake logic.

Verification
REQ-022 Single tile, default parameters: 9 beats of all pixels=1.0 (0x0100) and weight=0.5 (0x0080) -> out_valid one cycle after the 9th beat; every lane = 4.5 (0x0480); feature_idx=0; out_last=0.
REQ-023 Backpressure: out_ready held low for 5 cycles -> out_bus stable, pix_ready=0 and tap_idx=0 throughout; the tile is accepted on the first cycle out_ready=1.
REQ-024 Saturation: pixels=0x7FFF, weight=0x7FFF, 9 beats -> every lane = 0x7FFF. With pixels negated -> every lane = 0x8000, or 0x0000 when CONV_TILE_RELU_EN is defined.
REQ-025 Feature wrap: 4 consecutive tiles -> feature_idx 0,1,2,3 then 0; out_last=1 only on the 4th tile.
REQ-026 Abort: enable dropped after beat 4, then re-enabled -> no out_valid for the aborted tile; the next 9 beats produce a correct tile with feature_idx unchanged.
REQ-027 Reset mid-ACCUM at beat 6 -> all outputs 0 immediately; the next full tile is correct with no residue from the aborted accumulation.
